// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: state encoding, skid depth and default widths shared by the fifo_reader slice
package fifo_reader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_e;
  localparam int SKID_DEPTH = 2;
  localparam int DEF_BITS = 16;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: downstream valid/ready stream carrying words drained from the FIFO
interface fifo_reader_if import fifo_reader_pkg::*; #(parameter int BITS = DEF_BITS) ();
  logic [BITS-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, output valid, input ready);
  modport slave(input data, input valid, output ready);
endinterface

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry in-order valid/ready buffer; m.data is always the oldest entry
module fifo_reader_skid import fifo_reader_pkg::*; #(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [BITS-1:0] din,
  output logic [1:0]      occ,
  fifo_reader_if.master   m
);
  logic [BITS-1:0] d0, d1;
  logic xfer;
  logic [1:0] occ_s;
  always_comb begin
    xfer = m.valid & m.ready;
    occ_s = occ - {1'b0, xfer};
  end
  assign m.valid = occ != 2'd0;
  assign m.data = d0;
  // Drain first, then the pushed word lands in the first free slot after the shift
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      occ <= 2'd0;
      d0 <= '0;
      d1 <= '0;
    end else begin
      occ <= occ_s + {1'b0, push};
      d0 <= (push && occ_s == 2'd0) ? din : xfer ? d1 : d0;
      d1 <= (push && occ_s == 2'd1) ? din : d1;
    end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a show-ahead FIFO in counted or unlimited bursts onto a valid/ready stream.
// Optional FIFO_READER_STATS_EN adds a saturating stall_cycles counter.
module fifo_reader import fifo_reader_pkg::*; #(
  parameter int BITS  = DEF_BITS,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             pndng,
  input  logic [BITS-1:0]  fifo_dout,
  output logic             pop,
  fifo_reader_if.master    m,
  output logic             busy,
  output logic             burst_done,
  output logic [CNT_W-1:0] pop_count
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_FLUSH = FLUSH;
  logic [1:0] state, occ;
  logic [LEN_W-1:0] remaining;
  logic unlimited, by_count, last, count_end;
  always_comb begin
    pop = rst & (state == S_DRAIN) & pndng & (occ < 2'(SKID_DEPTH)) & (unlimited | (remaining != '0));
    last = pop & ~unlimited & (remaining == LEN_W'(1));
    count_end = ~unlimited & ((remaining == '0) | last);
    busy = state != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      remaining <= '0;
      unlimited <= 1'b0;
      by_count <= 1'b0;
      burst_done <= 1'b0;
      pop_count <= '0;
    end else begin
      burst_done <= 1'b0;
      pop_count <= pop_count + CNT_W'(pop);
      remaining <= remaining - LEN_W'(pop & ~unlimited);
      if (state == S_IDLE && en) begin
        state <= S_DRAIN;
        remaining <= burst_len;
        unlimited <= burst_len == '0;
      end else if (state == S_DRAIN && (!en || count_end)) begin
        state <= S_FLUSH;
        by_count <= count_end;
      end else if (state == S_FLUSH && occ == 2'd0) begin
        state <= S_IDLE;
        burst_done <= by_count;
      end
    end
`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cycles <= '0;
    else if (m.valid && !m.ready && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
`endif
  fifo_reader_skid #(.BITS(BITS)) u_skid (
    .clk(clk),
    .rst(rst),
    .push(pop),
    .din(fifo_dout),
    .occ(occ),
    .m(m)
  );
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed and randomized bursts against a queue-based FIFO and in-order scoreboard
module tb_fifo_reader;
  localparam int BITS = 16;
  localparam int LEN_W = 8;
  localparam int CNT_W = 16;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, pndng = 1'b0;
  logic pop, busy, burst_done;
  logic [LEN_W-1:0] burst_len = '0;
  logic [BITS-1:0] fifo_dout = '0;
  logic [CNT_W-1:0] pop_count;
`ifdef FIFO_READER_STATS_EN
  logic [CNT_W-1:0] stall_cycles;
`endif
  fifo_reader_if #(.BITS(BITS)) m_if ();
  fifo_reader #(.BITS(BITS), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .burst_len(burst_len),
    .pndng(pndng),
    .fifo_dout(fifo_dout),
    .pop(pop),
    .m(m_if),
    .busy(busy),
    .burst_done(burst_done),
    .pop_count(pop_count)
`ifdef FIFO_READER_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int npop, nrx, ndone, cyc, first_pop, first_rx, last_rx, exp_pc;
  logic [BITS-1:0] fifo[$];
  logic [BITS-1:0] exp_q[$];
  logic [BITS-1:0] hold_data, dummy;
  logic s_pop, s_x, hold;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic fifo_sync();
    pndng = fifo.size() != 0;
    fifo_dout = pndng ? fifo[0] : '0;
  endtask
  task automatic push(input logic [BITS-1:0] w);
    fifo.push_back(w);
    exp_q.push_back(w);
    fifo_sync();
  endtask
  // Words left in the FIFO after a test are removed so the next test starts clean
  task automatic drop();
    chk("scoreboard_drained", exp_q.size(), fifo.size());
    while (fifo.size() != 0) begin
      dummy = fifo.pop_back();
      dummy = exp_q.pop_back();
    end
    fifo_sync();
  endtask
  task automatic tick();
    @(negedge clk);
    s_pop = pop;
    s_x = m_if.valid & m_if.ready;
    if (s_pop) chk("pop_needs_pndng", pndng, 1);
    if (hold) chk("hold_stable", {m_if.valid, m_if.data}, {1'b1, hold_data});
    hold = m_if.valid & ~m_if.ready;
    hold_data = m_if.data;
    if (s_x) begin
      if (exp_q.size() == 0) chk("rx_extra", exp_q.size(), 1);
      else chk("rx_data", m_if.data, exp_q.pop_front());
      nrx++;
      if (first_rx < 0) first_rx = cyc;
      last_rx = cyc;
    end
    if (s_pop && first_pop < 0) first_pop = cyc;
    if (burst_done) ndone++;
    @(posedge clk);
    #1;
    cyc++;
    if (s_pop) begin
      npop++;
      if (fifo.size() != 0) dummy = fifo.pop_front();
    end
    fifo_sync();
  endtask
  task automatic start(input logic [LEN_W-1:0] len);
    npop = 0;
    nrx = 0;
    ndone = 0;
    first_pop = -1;
    first_rx = -1;
    burst_len = len;
    en = 1'b1;
  endtask
  task automatic wait_pops(input int n, input string tag);
    int k = 0;
    while (npop < n && k < 300) begin
      tick();
      k++;
    end
    chk(tag, npop, n);
  endtask
  task automatic finish_burst(input string tag);
    int k = 0;
    en = 1'b0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    chk(tag, busy, 0);
    tick();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    hold = 1'b0;
    cyc = 0;
    m_if.ready = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) push(BITS'(i));
    #1;
    chk("rst_pop", pop, 0);
    chk("rst_valid", m_if.valid, 0);
    chk("rst_data", m_if.data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_pop_count", pop_count, 0);
`ifdef FIFO_READER_STATS_EN
    chk("rst_stall", stall_cycles, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    start(4);
    wait_pops(4, "b4_pops");
    finish_burst("b4_idle");
    chk("b4_rx", nrx, 4);
    chk("b4_done", ndone, 1);
    chk("b4_pop_count", pop_count, 4);
    chk("b4_pndng", pndng, 1);
    chk("b4_left", fifo.size(), 2);
    drop();
    start(0);
    tick();
    for (int i = 0; i < 16; i++) begin
      push(BITS'($urandom));
      if (i == 15) en = 1'b0;
      tick();
    end
    finish_burst("unl_idle");
    chk("unl_pops", npop, 16);
    chk("unl_rx", nrx, 16);
    chk("unl_done", ndone, 0);
    chk("unl_latency", first_rx - first_pop, 1);
    chk("unl_rate", last_rx - first_rx, 15);
    chk("unl_pop_count", pop_count, 20);
    drop();
    for (int i = 0; i < 8; i++) push(BITS'($urandom));
    start(8);
    for (int k = 0; nrx < 3 && k < 100; k++) tick();
    chk("bp_pre_rx", nrx, 3);
    m_if.ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (j == 4) chk("bp_pop_stopped", s_pop, 0);
    end
    m_if.ready = 1'b1;
    wait_pops(8, "bp_pops");
    finish_burst("bp_idle");
    chk("bp_rx", nrx, 8);
    chk("bp_done", ndone, 1);
    chk("bp_pop_count", pop_count, 28);
`ifdef FIFO_READER_STATS_EN
    chk("bp_stall", stall_cycles, 5);
`endif
    drop();
    start(1);
    repeat (10) tick();
    chk("empty_no_pop", npop, 0);
    chk("empty_busy", busy, 1);
    push(BITS'($urandom));
    wait_pops(1, "empty_pops");
    finish_burst("empty_idle");
    chk("empty_rx", nrx, 1);
    chk("empty_done", ndone, 1);
    chk("empty_pop_count", pop_count, 29);
    drop();
    for (int i = 0; i < 10; i++) push(BITS'($urandom));
    start(10);
    wait_pops(2, "abort_pre");
    finish_burst("abort_idle");
    chk("abort_pops", npop, 3);
    chk("abort_rx", nrx, 3);
    chk("abort_done", ndone, 0);
    chk("abort_pop_count", pop_count, 32);
    chk("abort_left", fifo.size(), 7);
    drop();
    for (int i = 0; i < 8; i++) push(BITS'($urandom));
    m_if.ready = 1'b0;
    start(8);
    wait_pops(2, "rm_pops");
    tick();
    #3 rst = 1'b0;
    #1;
    chk("rm_pop", pop, 0);
    chk("rm_valid", m_if.valid, 0);
    chk("rm_data", m_if.data, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", burst_done, 0);
    chk("rm_pop_count", pop_count, 0);
`ifdef FIFO_READER_STATS_EN
    chk("rm_stall", stall_cycles, 0);
`endif
    hold = 1'b0;
    dummy = exp_q.pop_front();
    dummy = exp_q.pop_front();
    chk("rm_fifo_kept", fifo.size(), 6);
    m_if.ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    start(3);
    wait_pops(3, "rm_new_pops");
    finish_burst("rm_new_idle");
    chk("rm_new_rx", nrx, 3);
    chk("rm_new_done", ndone, 1);
    chk("rm_new_pop_count", pop_count, 3);
    drop();
    exp_pc = 3;
    repeat (4) begin
      int len, avail;
      len = $urandom_range(1, 12);
      avail = $urandom_range(len, len + 4);
      for (int i = 0; i < avail; i++) push(BITS'($urandom));
      start(LEN_W'(len));
      tick();
      burst_len = LEN_W'($urandom);
      for (int k = 0; npop < len && k < 400; k++) begin
        m_if.ready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("rnd_pops", npop, len);
      m_if.ready = 1'b1;
      finish_burst("rnd_idle");
      exp_pc += len;
      chk("rnd_rx", nrx, len);
      chk("rnd_done", ndone, 1);
      chk("rnd_pop_count", pop_count, exp_pc);
      chk("rnd_left", fifo.size(), avail - len);
      drop();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Consumer end of the fifo_flops push/pop interface.
- Drains a fifo_flops instance through its pop/pndng/Dout side and re-presents the data on a downstream valid/ready stream.
- Drains either a programmed burst of words or continuously while enabled.
- Sits between the FIFO and any sink that can apply backpressure.

Parameters:
- BITS, 16, data width; matches fifo_flops BITS.
- LEN_W, 8, width of burst_len and of the remaining-word counter.
- CNT_W, 16, width of pop_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset; rst=0 resets the block immediately, independent of clk.
- en  in  1  drain enable, level.
- burst_len  in  LEN_W  words per burst; 0 = unlimited, drain while en=1.
- pndng  in  1  FIFO non-empty; head word valid on fifo_dout.
- fifo_dout  in  BITS  FIFO head word (show-ahead), valid while pndng=1.
- pop  out  1  FIFO pop; removes the head at the rising edge where pop=1.
- m_data  out  BITS  downstream data.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts; a transfer occurs on any edge with m_valid=1 and m_ready=1.
- busy  out  1  high in DRAIN or FLUSH.
- burst_done  out  1  one-cycle pulse when a counted burst has fully left the block.
- pop_count  out  CNT_W  total words popped since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; skid occupancy=0.
  - m_valid=0, m_data=0, busy=0, burst_done=0, pop_count=0, remaining=0.
  - pop must read 0 while rst=0.
- pop is combinational: pop = (state==DRAIN) & pndng & (occ<2) & (unlimited | remaining!=0).
  - pop is never asserted with pndng=0; underflow is impossible by construction.
- On every edge with pop=1:
  - fifo_dout is written into the 2-entry skid buffer.
  - pop_count increments.
  - remaining decrements when the burst is counted.
- Latency: a word popped at edge N appears on m_data with m_valid=1 after edge N (visible in cycle N+1).
  - Sustained throughput is 1 word/clk while m_ready=1.
- Skid buffer is 2 entries, in order.
  - m_valid = (occ!=0); m_data = oldest entry.
  - Same-edge push and transfer keeps occ unchanged.
  - No data is lost or duplicated under any m_ready pattern.
  - m_data and m_valid stay stable while m_valid=1 and m_ready=0.
- FSM:
  - IDLE: busy=0. When en=1, latch burst_len into remaining, set unlimited=(burst_len==0), go to DRAIN.
  - DRAIN: pop per the rule above. Go to FLUSH when en=0, or when the burst is counted and remaining reaches 0 (including on the same edge as the last pop).
  - FLUSH: no pops. When occ==0: go to IDLE, and pulse burst_done for 1 cycle (during the IDLE cycle) only if the burst completed by count. An en=0 abort gives no pulse.
- Boundary cases:
  - FIFO empty in DRAIN (pndng=0): stay in DRAIN, pop=0, no timeout.
  - en toggling to 1 during FLUSH: ignored until IDLE is reached.
  - burst_len changes after latch: no effect on the current burst.
  - Reset mid-burst: buffered words are discarded; the FIFO retains unpopped words.

Optional Feature:
- Macro: FIFO_READER_STATS_EN.
- Defined:
  - Adds output stall_cycles (CNT_W bits).
  - Counts cycles with m_valid=1 and m_ready=0; saturates at all-ones.
  - Reset value 0.
- Undefined:
  - Port absent; no counter logic.
  - All other behaviour identical.

Decomposition:
- fifo_reader_pkg holds:
  - the state enum (IDLE, DRAIN, FLUSH);
  - the SKID_DEPTH=2 constant;
  - default width constants.
- Sub-module fifo_reader_skid: the 2-entry valid/ready buffer (push, data in, occ out, m_* side).
  - The FSM, counters and pop logic stay in fifo_reader.

Test Plan:
- Burst of 4 words:
  - Stimulus: preload 6 words 0..5, burst_len=4, en=1, m_ready=1.
  - Response: exactly 4 pops; m_data 0,1,2,3 in order; one burst_done pulse; pop_count=4; words 4 and 5 remain in the FIFO (pndng=1).
- Unlimited drain:
  - Stimulus: burst_len=0, en=1, m_ready=1, 16 words pushed at 1/clk.
  - Response: 16 transfers at 1/clk after a 1-cycle latency; no burst_done.
- Backpressure:
  - Stimulus: burst_len=8, m_ready low for 5 cycles mid-burst.
  - Response: pop stops with occ=2; m_data held stable; all 8 words delivered in order.
  - With FIFO_READER_STATS_EN: stall_cycles=5.
- Empty FIFO:
  - Stimulus: en=1, pndng=0 for 10 cycles, then 1 word pushed.
  - Response: pop never asserted with pndng=0; the word is delivered.
- Abort:
  - Stimulus: en deasserted after 3 of 10 pops.
  - Response: 3 words delivered, FLUSH then IDLE, no burst_done, pop_count=3.
- Async reset mid-burst:
  - Stimulus: rst=0 between clk edges with occ=2.
  - Response: m_valid=0 and pop=0 immediately; all outputs at reset values; a new burst works after rst=1.
